// File: rtl/counter_checker_if.sv
// Signal bundle between a mod-M up/down counter and its checker.
// The counter side drives everything; the checker only observes.
interface counter_checker_if #(
  parameter int N = 3
);
  logic         syn_clr;
  logic         load;
  logic         en;
  logic         up;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         max_tick;
  logic         min_tick;

  modport master (output syn_clr, load, en, up, d, q, max_tick, min_tick);
  modport slave  (input  syn_clr, load, en, up, d, q, max_tick, min_tick);
endinterface

// File: rtl/counter_checker.sv
// Cycle-by-cycle monitor for a mod-M up/down counter: predicts q from the
// previous cycle's controls, checks value/ticks/range, logs the first failure.
module counter_checker #(
  parameter int N     = 3,
  parameter int M     = 8,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_chk_en,
  counter_checker_if.slave mon,
  output logic             o_err_pulse,
  output logic             o_err_flag,
  output logic [2:0]       o_err_cause,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [ERR_W-1:0] o_cyc_cnt,
  output logic [N-1:0]     o_first_q,
  output logic [N-1:0]     o_first_exp,
  output logic [ERR_W-1:0] o_first_cyc
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CHECK} state_t;

  localparam logic [N-1:0] Q_MAX = N'(M - 1);

  state_t           r_state;
  logic             r_err_pulse;
  logic             r_err_flag;
  logic [2:0]       r_err_cause;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] r_cyc_cnt;
  logic [N-1:0]     r_first_q;
  logic [N-1:0]     r_first_exp;
  logic [ERR_W-1:0] r_first_cyc;

  logic             r_syn_clr;
  logic             r_load;
  logic             r_en;
  logic             r_up;
  logic [N-1:0]     r_d;
  logic [N-1:0]     r_q;

  logic [N-1:0]     w_exp;
  logic [2:0]       w_cause;
  logic             w_fail;

  // NOTE: the sample registers are written in ARM before CHECK ever reads
  // them, so they carry no reset and need none.
  always_ff @(posedge clk) begin
    if (!rst && r_state != S_IDLE) begin
      r_syn_clr <= mon.syn_clr;
      r_load    <= mon.load;
      r_en      <= mon.en;
      r_up      <= mon.up;
      r_d       <= mon.d;
      r_q       <= mon.q;
    end
  end

  // NOTE: every variable gets a default before the if-chain so no latch is
  // inferred when no branch is taken.
  always_comb begin
    w_exp = r_q;
    if (r_syn_clr)         w_exp = '0;
    else if (r_load)       w_exp = r_d;
    else if (r_en && r_up) w_exp = (r_q == Q_MAX) ? '0 : r_q + N'(1);
    else if (r_en)         w_exp = (r_q == '0) ? Q_MAX : r_q - N'(1);
  end

  // Cause vector: [0] value, [1] tick, [2] out-of-range q.
  always_comb begin
    w_cause    = 3'b000;
    w_cause[0] = (mon.q != w_exp);
    w_cause[1] = (mon.max_tick != (mon.q == Q_MAX)) || (mon.min_tick != (mon.q == '0));
    w_cause[2] = ({1'b0, mon.q} >= (N+1)'(M));
    w_fail     = (r_state == S_CHECK) && (w_cause != 3'b000);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_err_pulse <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_cause <= 3'b000;
      r_err_cnt   <= '0;
      r_cyc_cnt   <= '0;
      r_first_q   <= '0;
      r_first_exp <= '0;
      r_first_cyc <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        S_IDLE:  if (i_chk_en) r_state <= S_ARM;
        S_ARM:   r_state <= i_chk_en ? S_CHECK : S_IDLE;
        S_CHECK: begin
          if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + ERR_W'(1);
          if (w_fail) begin
            r_err_pulse <= 1'b1;
            r_err_cause <= w_cause;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (!r_err_flag) begin
              r_err_flag  <= 1'b1;
              r_first_q   <= mon.q;
              r_first_exp <= w_exp;
              r_first_cyc <= r_cyc_cnt;
            end
          end
          if (!i_chk_en) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_err_pulse = r_err_pulse;
  assign o_err_flag  = r_err_flag;
  assign o_err_cause = r_err_cause;
  assign o_err_cnt   = r_err_cnt;
  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_first_q   = r_first_q;
  assign o_first_exp = r_first_exp;
  assign o_first_cyc = r_first_cyc;

endmodule
